// File: rtl/lcd_hd44780_rx.sv
// lcd_hd44780_rx: receiver end of the 4-bit HD44780 bus; decodes the driver's
// command subset and keeps a 2x16 character image (char 0 in screen[255:248]).
module lcd_hd44780_rx #(
    parameter int CLR_CYCLES  = 80000,
    parameter int EXEC_CYCLES = 2000
) (
    input  logic         CCLK,
    input  logic         rst,
    input  logic         LCDE,
    input  logic         LCDRS,
    input  logic         LCDRW,
    input  logic [3:0]   LCDDAT,
    output logic [255:0] screen,
    output logic         byte_valid,
    output logic [7:0]   byte_out,
    output logic         byte_rs,
    output logic         busy,
    output logic         four_bit,
    output logic         proto_err
);
    localparam int CW = $clog2((CLR_CYCLES > EXEC_CYCLES ? CLR_CYCLES : EXEC_CYCLES) + 1);

    typedef enum logic [1:0] {INIT8, HI, LO} state_e;

    state_e        state_q, state_d;
    logic [6:0]    s1_q, s2_q;
    logic          e_prev_q;
    logic [3:0]    hi_q;
    logic [CW-1:0] cnt_q;
    logic [6:0]    addr_q, addr_step;
    logic          inc_q, four_bit_q, proto_err_q, byte_valid_q, byte_rs_q;
    logic [7:0]    byte_out_q, acc_byte;
    logic [7:0]    cell_q [32];
    logic          ev, take, acc, cmd, dat_wr, long_cmd;

    // s2_q = {E, RS, RW, DAT}; everything is decoded from this one synced stage
    assign ev         = e_prev_q & ~s2_q[6];
    assign busy       = cnt_q != '0;
    assign take       = ev & ~s2_q[4] & ~busy;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign byte_rs    = byte_rs_q;
    assign four_bit   = four_bit_q;
    assign proto_err  = proto_err_q;

    for (genvar i = 0; i < 32; i++) begin : g_scr
        assign screen[255-8*i -: 8] = cell_q[i];
    end

    always_ff @(posedge CCLK) begin
        if (rst) state_q <= INIT8;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (take)
            state_d = state_q == HI ? LO :
                      state_q == LO ? HI :
                      s2_q[3:0] == 4'h2 ? HI : INIT8;
    end

    always_comb begin
        acc       = take & (state_q != HI);
        acc_byte  = state_q == LO ? {hi_q, s2_q[3:0]} : {s2_q[3:0], 4'h0};
        cmd       = acc & (state_q == LO) & ~s2_q[5];
        dat_wr    = acc & (state_q == LO) & s2_q[5];
        long_cmd  = cmd & (acc_byte[7:1] == 7'b0000001 || acc_byte == 8'h01);
        addr_step = inc_q ? (addr_q == 7'h0F ? 7'h40 : addr_q == 7'h4F ? 7'h00 : addr_q + 7'd1)
                          : (addr_q == 7'h40 ? 7'h0F : addr_q == 7'h00 ? 7'h4F : addr_q - 7'd1);
    end

    always_ff @(posedge CCLK) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            e_prev_q     <= 1'b0;
            hi_q         <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            inc_q        <= 1'b1;
            four_bit_q   <= 1'b0;
            proto_err_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_out_q   <= '0;
            byte_rs_q    <= 1'b0;
            for (int j = 0; j < 32; j++) cell_q[j] <= 8'h20;
        end else begin
            s1_q         <= {LCDE, LCDRS, LCDRW, LCDDAT};
            s2_q         <= s1_q;
            e_prev_q     <= s2_q[6];
            byte_valid_q <= acc;
            cnt_q        <= acc ? (long_cmd ? CW'(CLR_CYCLES) : CW'(EXEC_CYCLES)) :
                            busy ? cnt_q - 1'b1 : cnt_q;
            if (ev & (s2_q[4] | busy)) proto_err_q <= 1'b1;
            if (take && state_q == HI) hi_q <= s2_q[3:0];
            if (acc) begin
                byte_out_q <= acc_byte;
                byte_rs_q  <= s2_q[5];
            end
            if (acc && state_q == INIT8 && s2_q[3:0] == 4'h2) four_bit_q <= 1'b1;
            if (cmd) begin
                if (acc_byte[7]) addr_q <= acc_byte[6:0];
                else if (acc_byte[7:2] == 6'b000001) inc_q <= acc_byte[1];
                else if (acc_byte[7:1] == 7'b0000001) addr_q <= '0;
                else if (acc_byte == 8'h01) begin
                    addr_q <= '0;
                    inc_q  <= 1'b1;
                    for (int j = 0; j < 32; j++) cell_q[j] <= 8'h20;
                end
            end
            if (dat_wr) begin
                if (addr_q[5:4] == 2'b00) cell_q[{addr_q[6], addr_q[3:0]}] <= acc_byte;
                addr_q <= addr_step;
            end
        end
    end
endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// tb_lcd_hd44780_rx: directed plus randomized bus traffic checked against a
// character-level model of the display (cells, cursor address, entry direction).
module tb_lcd_hd44780_rx;
    localparam int CLR = 60;
    localparam int EXE = 20;

    logic         CCLK = 0, rst = 1, LCDE = 0, LCDRS = 0, LCDRW = 0;
    logic [3:0]   LCDDAT = '0;
    logic [255:0] screen;
    logic         byte_valid, byte_rs, busy, four_bit, proto_err;
    logic [7:0]   byte_out;

    lcd_hd44780_rx #(.CLR_CYCLES(CLR), .EXEC_CYCLES(EXE)) dut (
        .CCLK(CCLK), .rst(rst), .LCDE(LCDE), .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDDAT(LCDDAT),
        .screen(screen), .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs),
        .busy(busy), .four_bit(four_bit), .proto_err(proto_err)
    );

    always #5 CCLK = ~CCLK;

    int npass = 0, ntotal = 0, vcount = 0;
    always @(negedge CCLK) if (byte_valid === 1'b1) vcount <= vcount + 1;

    // reference model
    logic [7:0] m_scr [32];
    int         m_addr, m_vc;
    logic       m_inc, m_four, m_rs;
    logic [7:0] m_last;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_scr[i] = 8'h20;
        m_addr = 0; m_inc = 1; m_four = 0; m_rs = 0; m_last = 0;
    endtask

    function automatic logic [255:0] exp_scr();
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[255-8*i -: 8] = m_scr[i];
        return r;
    endfunction

    task automatic model_byte(input logic rs, input logic [7:0] b);
        int v;
        v = int'(b);
        m_vc++; m_last = b; m_rs = rs;
        if (rs) begin
            if (m_addr < 16) m_scr[m_addr] = b;
            else if (m_addr >= 64 && m_addr < 80) m_scr[m_addr - 48] = b;
            if (m_inc) m_addr = m_addr == 15 ? 64 : m_addr == 79 ? 0 : (m_addr + 1) % 128;
            else       m_addr = m_addr == 64 ? 15 : m_addr == 0 ? 79 : (m_addr + 127) % 128;
        end else if (v >= 128) m_addr = v - 128;
        else if (v >= 8) begin end
        else if (v >= 4) m_inc = b[1];
        else if (v >= 2) m_addr = 0;
        else if (v == 1) begin
            for (int i = 0; i < 32; i++) m_scr[i] = 8'h20;
            m_addr = 0; m_inc = 1;
        end
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [3:0] d);
        LCDRS = rs; LCDRW = rw; LCDDAT = d;
        repeat (2) @(negedge CCLK);
        LCDE = 1;
        repeat (4) @(negedge CCLK);
        LCDE = 0;
        repeat (6) @(negedge CCLK);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge CCLK);
            n++;
        end
        check("idle_timeout", 256'(n < 500), 256'(1));
    endtask

    task automatic send8(input logic [3:0] d);
        strobe(0, 0, d);
        m_vc++; m_last = {d, 4'h0}; m_rs = 0;
        if (d == 4'h2) m_four = 1;
        check("init_busy", 256'(busy), 256'(1));
        wait_idle();
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        strobe(rs, 0, b[7:4]);
        strobe(rs, 0, b[3:0]);
        model_byte(rs, b);
        wait_idle();
    endtask

    task automatic check_all(input string tag);
        check({tag, "_screen"}, screen, exp_scr());
        check({tag, "_byte_out"}, 256'(byte_out), 256'(m_last));
        check({tag, "_byte_rs"}, 256'(byte_rs), 256'(m_rs));
        check({tag, "_vcount"}, 256'(vcount), 256'(m_vc));
        check({tag, "_four_bit"}, 256'(four_bit), 256'(m_four));
    endtask

    task automatic do_reset();
        rst = 1; LCDE = 0; LCDRW = 0;
        repeat (3) @(negedge CCLK);
        rst = 0;
        model_reset();
        @(negedge CCLK);
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        m_vc = 0;
        do_reset();
        check("rst_screen", screen, {32{8'h20}});
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_proto", 256'(proto_err), 256'(0));
        check("rst_valid", 256'(byte_valid), 256'(0));
        check_all("rst");

        send8(4'h3); send8(4'h3); send8(4'h3);
        check_all("init30");
        send8(4'h2);
        check_all("init20");
        send_byte(0, 8'h28);
        check_all("fset");

        send_byte(0, 8'h01);
        send_byte(1, "A");
        send_byte(1, "B");
        check("ab", 256'(screen[255:240]), 256'(16'h4142));
        check_all("ab");

        send_byte(0, 8'h8F); send_byte(1, "X"); send_byte(1, "Y");
        check_all("wrap_fwd");
        send_byte(0, 8'h04); send_byte(0, 8'hC0); send_byte(1, "Z"); send_byte(1, "W");
        check_all("wrap_back");
        send_byte(0, 8'h02); send_byte(1, "H");
        check_all("home");

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: b = 8'h80 | 8'($urandom_range(0, 127));
                1: b = 8'h04 | 8'($urandom_range(0, 3));
                2: b = 8'($urandom_range(8, 63));
                3: b = 8'h01;
                default: b = 8'hFF;
            endcase
            if (b == 8'hFF) send_byte(1, 8'($urandom_range(33, 126)));
            else send_byte(0, b);
            check_all("rand");
        end

        strobe(1, 1, 4'h5);
        check("rw_proto", 256'(proto_err), 256'(1));
        check_all("rw");

        strobe(1, 0, 4'h4);
        rst = 1;
        repeat (2) @(negedge CCLK);
        rst = 0;
        model_reset();
        @(negedge CCLK);
        check("midrst_proto", 256'(proto_err), 256'(0));
        check("midrst_busy", 256'(busy), 256'(0));
        check_all("midrst");

        send8(4'h2);
        strobe(1, 0, 4'h5);
        strobe(1, 0, 4'h1);
        model_byte(1, 8'h51);
        check("busy_set", 256'(busy), 256'(1));
        strobe(1, 0, 4'h7);
        check("busy_proto", 256'(proto_err), 256'(1));
        check_all("busy_drop");
        wait_idle();
        send_byte(1, "R");
        check_all("after_drop");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
